// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Purpose:
//   Accepts one ALU request at a time, registers the operands and opcode onto a
//   multi-cycle ALU, waits a fixed number of cycles (DIV_LAT for DIV, ALU_LAT
//   for every other op), captures the ALU result and presents it as a response
//   held until the consumer takes it. Illegal opcodes never reach the ALU; they
//   produce an error response one cycle after acceptance.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   req_valid    request present
//   req_ready    sequencer idle and able to accept a request
//   req_op       4-bit ALU operation code
//   req_a        operand A
//   req_b        operand B (shift/rotate amount in req_b[4:0])
//   alu_A        operand A held on the ALU input
//   alu_B        operand B held on the ALU input
//   alu_control  opcode held on the ALU input
//   alu_Zlow     ALU low result
//   alu_Zhigh    ALU high result (0 for everything except MUL/DIV)
//   rsp_valid    response present
//   rsp_ready    consumer accepts the response
//   rsp_lo       captured low result
//   rsp_hi       captured high result
//   rsp_err      response belongs to an illegal opcode
//   busy         request in flight or response pending
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int ALU_LAT = 2,
    parameter int DIV_LAT = 34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_Zlow,
    input  logic [31:0] alu_Zhigh,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        rsp_err,
    output logic        busy
);

    localparam int          DATA_W  = 32;
    localparam logic [3:0]  OP_DIV  = 4'b1111;
    localparam logic [5:0]  ALU_CNT = ALU_LAT[5:0];
    localparam logic [5:0]  DIV_CNT = DIV_LAT[5:0];

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [5:0] cnt;
    logic       illegal;
    logic       accept;
    logic       capture;

    // 1011, 1100 and 1101 are unassigned on the ALU.
    function automatic logic op_is_legal(input logic [3:0] op);
        return !(op == 4'b1011 || op == 4'b1100 || op == 4'b1101);
    endfunction

    function automatic logic [5:0] op_latency(input logic [3:0] op);
        return (op == OP_DIV) ? DIV_CNT : ALU_CNT;
    endfunction

    // ---- control: state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- control: next state and handshake outputs ----
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b0;

        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                busy = 1'b1;
                // Capture on the last counted edge so the response appears
                // exactly the configured latency after acceptance.
                if (cnt == 6'd1) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---- datapath: operand launch, latency count, result capture ----
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= 6'd0;
            illegal     <= 1'b0;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_control <= 4'd0;
            rsp_lo      <= '0;
            rsp_hi      <= '0;
            rsp_err     <= 1'b0;
        end else begin
            if (accept) begin
                if (op_is_legal(req_op)) begin
                    alu_A       <= req_a;
                    alu_B       <= req_b;
                    alu_control <= req_op;
                    illegal     <= 1'b0;
                    cnt         <= op_latency(req_op);
                end else begin
                    // ALU inputs stay on the previous op; a one-cycle pass
                    // through EXEC turns into the error response.
                    illegal <= 1'b1;
                    cnt     <= 6'd1;
                end
            end else if (state == EXEC) begin
                cnt <= cnt - 6'd1;
            end

            if (capture) begin
                rsp_lo  <= illegal ? {DATA_W{1'b0}} : alu_Zlow;
                rsp_hi  <= illegal ? {DATA_W{1'b0}} : alu_Zhigh;
                rsp_err <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [31:0] alu_A;
    logic [31:0] alu_B;
    logic [3:0]  alu_control;
    logic [31:0] alu_Zlow;
    logic [31:0] alu_Zhigh;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_err;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // Operands the ALU should currently be holding (last legal acceptance).
    logic [3:0]  last_op;
    logic [31:0] last_a;
    logic [31:0] last_b;

    alu_sequencer #(.ALU_LAT(2), .DIV_LAT(34)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_control(alu_control),
        .alu_Zlow   (alu_Zlow),
        .alu_Zhigh  (alu_Zhigh),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_lo     (rsp_lo),
        .rsp_hi     (rsp_hi),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {high, low}.
    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0]  sh;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [63:0] wide;
        sh = b[4:0];
        lo = 32'd0;
        hi = 32'd0;
        wide = 64'd0;
        case (op)
            4'd0:  lo = a + b;
            4'd1:  lo = a - b;
            4'd2:  lo = a & b;
            4'd3:  lo = a | b;
            4'd4:  lo = a ^ b;
            4'd5:  lo = a << sh;
            4'd6:  lo = a >> sh;
            4'd7:  lo = $unsigned($signed(a) >>> sh);
            4'd8:  begin wide = {a, a} << sh; lo = wide[63:32]; end
            4'd9:  begin wide = {a, a} >> sh; lo = wide[31:0];  end
            4'd10: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd14: begin wide = {32'd0, a} * {32'd0, b}; hi = wide[63:32]; lo = wide[31:0]; end
            4'd15: begin
                if (b != 32'd0) begin
                    lo = a / b;
                    hi = a % b;
                end else begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                end
            end
            default: ;
        endcase
        return {hi, lo};
    endfunction

    always_comb begin
        {alu_Zhigh, alu_Zlow} = ref_alu(alu_control, alu_A, alu_B);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: accept, wait for the response, hold it under
    // backpressure for 'hold' cycles, then hand it off.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit ready_early);
        bit          legal;
        int          lat;
        int          n;
        bit          saw_ready;
        logic [63:0] exp;
        legal = !(op == 4'd11 || op == 4'd12 || op == 4'd13);
        lat   = !legal ? 1 : ((op == 4'd15) ? 34 : 2);
        exp   = legal ? ref_alu(op, a, b) : 64'd0;

        chk("idle_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        step();
        req_valid = 1'b0;
        req_op    = 4'($urandom_range(0, 15));
        req_a     = $urandom;
        req_b     = $urandom;
        if (legal) begin
            last_op = op;
            last_a  = a;
            last_b  = b;
        end

        // rsp_ready asserted while nothing is valid must be harmless.
        rsp_ready = ready_early;
        n = 0;
        saw_ready = 1'b0;
        while (!rsp_valid && n < 200) begin
            if (req_ready) saw_ready = 1'b1;
            step();
            n++;
        end
        rsp_ready = 1'b0;

        chk("latency", 64'(n), 64'(lat));
        chk("ready_in_exec", 64'(saw_ready), 64'd0);
        chk("rsp_lo", 64'(rsp_lo), 64'(exp[31:0]));
        chk("rsp_hi", 64'(rsp_hi), 64'(exp[63:32]));
        chk("rsp_err", 64'(rsp_err), legal ? 64'd0 : 64'd1);
        chk("busy_done", 64'(busy), 64'd1);
        chk("alu_ctl", 64'(alu_control), 64'(last_op));
        chk("alu_ab", {alu_A, alu_B}, {last_a, last_b});

        // Backpressure with a competing request that must not be taken.
        req_valid = 1'b1;
        req_op    = 4'd0;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_data", {rsp_hi, rsp_lo}, exp);
            chk("bp_alu", 64'(alu_control), 64'(last_op));
        end

        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        chk("hs_valid", 64'(rsp_valid), 64'd0);
        chk("hs_req_ready", 64'(req_ready), 64'd1);
        chk("hs_busy", 64'(busy), 64'd0);
        chk("hs_retain", {rsp_hi, rsp_lo}, exp);
        chk("hs_alu", 64'(alu_control), 64'(last_op));
    endtask

    initial begin
        int  n;
        bit  saw;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_op    = 4'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        last_op   = 4'd0;
        last_a    = 32'd0;
        last_b    = 32'd0;
        repeat (3) step();

        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_alu", {28'd0, alu_control, alu_A}, 64'd0);
        chk("rst_rsp", {31'd0, rsp_err, rsp_lo}, 64'd0);
        reset = 1'b0;
        step();

        // ADD 5 + 7
        run_op(4'd0, 32'd5, 32'd7, 0, 1'b0);
        chk("add_lo", 64'(rsp_lo), 64'd12);
        chk("add_hi", 64'(rsp_hi), 64'd0);

        // MUL 0x10000 * 0x10000
        run_op(4'd14, 32'h0001_0000, 32'h0001_0000, 1, 1'b1);
        chk("mul_hi", 64'(rsp_hi), 64'd1);
        chk("mul_lo", 64'(rsp_lo), 64'd0);

        // DIV 100 / 7
        run_op(4'd15, 32'd100, 32'd7, 0, 1'b0);
        chk("div_lo", 64'(rsp_lo), 64'd14);
        chk("div_hi", 64'(rsp_hi), 64'd2);

        // Illegal op after DIV: ALU must keep the DIV opcode.
        run_op(4'd12, 32'h1234, 32'h5678, 0, 1'b0);
        chk("ill_alu_ctl", 64'(alu_control), 64'd15);
        chk("ill_err", 64'(rsp_err), 64'd1);

        // ADD held off for 5 cycles with a request waiting.
        run_op(4'd0, 32'hFFFF_FFFF, 32'd2, 5, 1'b0);
        chk("bp_add_lo", 64'(rsp_lo), 64'd1);

        // Other illegal codes and shifts.
        run_op(4'd11, 32'd1, 32'd1, 0, 1'b0);
        run_op(4'd13, 32'd1, 32'd1, 2, 1'b1);
        run_op(4'd7, 32'h8000_0000, 32'd31, 0, 1'b0);
        run_op(4'd8, 32'h8000_0001, 32'd0, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (op == 4'd15 && b == 32'd0) b = 32'd1;
            run_op(op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset ten cycles into a DIV aborts it with no response.
        req_valid = 1'b1;
        req_op    = 4'd15;
        req_a     = 32'd1000;
        req_b     = 32'd3;
        step();
        req_valid = 1'b0;
        repeat (9) step();
        chk("mid_div_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_req_ready", 64'(req_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(rsp_valid), 64'd0);
        chk("abort_alu", {28'd0, alu_control, alu_A}, 64'd0);
        chk("abort_rsp", {rsp_hi, rsp_lo}, 64'd0);
        last_op = 4'd0;
        last_a  = 32'd0;
        last_b  = 32'd0;
        n = 0;
        saw = 1'b0;
        while (n < 40) begin
            if (rsp_valid || busy) saw = 1'b1;
            step();
            n++;
        end
        chk("abort_no_rsp", 64'(saw), 64'd0);

        // Reset wins over a simultaneous request.
        req_valid = 1'b1;
        req_op    = 4'd0;
        req_a     = 32'd3;
        req_b     = 32'd4;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        req_valid = 1'b0;
        chk("rst_vs_req_busy", 64'(busy), 64'd0);
        chk("rst_vs_req_alu", 64'(alu_A), 64'd0);

        // Reset wins over a response handshake.
        run_op(4'd4, 32'hA5A5_0000, 32'h0000_5A5A, 0, 1'b0);
        req_valid = 1'b1;
        req_op    = 4'd1;
        req_a     = 32'd9;
        req_b     = 32'd4;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        rsp_ready = 1'b0;
        chk("rst_vs_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_vs_rsp_data", {31'd0, rsp_err, rsp_lo}, 64'd0);
        last_op = 4'd0;
        last_a  = 32'd0;
        last_b  = 32'd0;

        run_op(4'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
